// File: rtl/gups_pkg.sv
// Shared types and constants for the GUPS read-modify-write engine.
// Optional build macro used by the engine: GUPS_PERF_CNT_EN (stall/run cycle counters).
package gups_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_MODIFY,
        ST_WR_REQ,
        ST_NEXT,
        ST_DONE
    } state_e;

    localparam logic [15:0] LFSR_TAP      = 16'hB400;
    localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

endpackage

// File: rtl/gups_lfsr.sv
// One Galois right-shift LFSR address stream; load takes priority over step.
module gups_lfsr
    import gups_pkg::*;
#(
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            // An all-zero state would lock the LFSR, so substitute a legal seed.
            lfsr_d = (seed == '0) ? LFSR_W'(LFSR_ZERO_SUB) : seed;
        end else if (step) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_W'(LFSR_TAP) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/gups_rmw_engine.sv
// GUPS read-modify-write engine: round-robin LFSR lanes drive read, add INC, write back.
// Define GUPS_PERF_CNT_EN to add the saturating stall_cycles/run_cycles outputs.
module gups_rmw_engine
    import gups_pkg::*;
#(
    parameter int          DATA_W    = 64,
    parameter int          ADDR_W    = 64,
    parameter int          NUM_LANES = 4,
    parameter int          LFSR_W    = 16,
    parameter int unsigned INC       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 num_updates,
    input  logic [NUM_LANES*LFSR_W-1:0] seed,
    input  logic [ADDR_W-1:0]           range,
    output logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic                        req,
    output logic                        wr,
    input  logic                        rdy,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 update_cnt
`ifdef GUPS_PERF_CNT_EN
   ,output logic [31:0]                 stall_cycles,
    output logic [31:0]                 run_cycles
`endif
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [31:0]         num_q, num_d;
    logic [ADDR_W-1:0]   range_q, range_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                start_acc;
    logic                step_lane;
    logic [LFSR_W-1:0]   lane_val [NUM_LANES];
    logic [NUM_LANES-1:0] lane_step;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_step[i] = step_lane && (ptr_q == PTR_W'(i));
        gups_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .load  (start_acc),
            .step  (lane_step[i]),
            .seed  (seed[i*LFSR_W +: LFSR_W]),
            .value (lane_val[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        num_d     = num_q;
        range_d   = range_q;
        rdata_d   = rdata_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        start_acc = 1'b0;
        step_lane = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    num_d     = num_updates;
                    range_d   = range;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    ptr_d     = '0;
                    state_d   = (num_updates == '0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (rdy) begin
                    rdata_d = din;
                    state_d = ST_MODIFY;
                end
            end
            ST_MODIFY: begin
                dout_d  = rdata_q + DATA_W'(INC);
                state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (rdy) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                step_lane = 1'b1;
                ptr_d     = (ptr_q == PTR_W'(NUM_LANES - 1)) ? '0 : ptr_q + PTR_W'(1);
                state_d   = (cnt_q == num_q) ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            num_q   <= '0;
            range_q <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            num_q   <= num_d;
            range_q <= range_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // req is decoded from state so a reset edge drops it immediately.
    assign req        = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign wr         = (state_q == ST_WR_REQ);
    assign addr       = ADDR_W'(lane_val[ptr_q]) & range_q;
    assign dout       = dout_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign update_cnt = cnt_q;

`ifdef GUPS_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] run_q, run_d;

    always_comb begin
        stall_d = stall_q;
        run_d   = run_q;
        if (start_acc) begin
            stall_d = '0;
            run_d   = '0;
        end else begin
            if (req && !rdy && (stall_q != '1)) stall_d = stall_q + 32'd1;
            if (busy_q && (run_q != '1))        run_d   = run_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            run_q   <= '0;
        end else begin
            stall_q <= stall_d;
            run_q   <= run_d;
        end
    end

    assign stall_cycles = stall_q;
    assign run_cycles   = run_q;
`endif

endmodule
